// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : mc_controller
// Description : Control unit for a multicycle ARM-like CPU.
//               - Decodes Cond/Op/Funct from the instruction register.
//               - Steps the main FSM through fetch, decode, execute, memory
//                 and writeback.
//               - Holds the NZCV flag register and the per-instruction
//                 condition result.
//               - Drives every enable and mux select of the shared-memory
//                 datapath.
// Optional    : CMP_NOWB_EN -- Funct[4:1]=1010 decodes as a compare: SUB with
//               flag write and no register/PC writeback.
// Ports       : clk        rising-edge clock
//               reset      asynchronous active-low reset
//               Cond/Op/Funct/Rd  instruction fields
//               ALUFlags   {N,Z,C,V} from the ALU
//               PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
//               ALUSrcB, ALUControl, ImmSrc, RegSrc, RegWrite
//                          datapath controls
// Revision    : 1.0 - initial release
// ============================================================================
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic       RegWrite
);

  localparam logic [3:0] FETCH_STATE = 4'd0;

  typedef enum logic [3:0] {
    FETCH    = FETCH_STATE,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] flags;        // {N,Z,C,V}
  logic       cond_ex;
  logic       cond_ex_r;
  logic [1:0] dp_ctrl;
  logic [1:0] flag_w;
  logic       no_write;
  logic       wb_en;

  // ---------------- data-processing decode ----------------
  always_comb begin
    dp_ctrl  = 2'b00;
    flag_w   = 2'b00;
    no_write = 1'b0;
    case (Funct[4:1])
      4'b0100: begin dp_ctrl = 2'b00; flag_w = 2'b11; end
      4'b0010: begin dp_ctrl = 2'b01; flag_w = 2'b11; end
      4'b0000: begin dp_ctrl = 2'b10; flag_w = 2'b10; end
      4'b1100: begin dp_ctrl = 2'b11; flag_w = 2'b10; end
`ifdef CMP_NOWB_EN
      4'b1010: begin dp_ctrl = 2'b01; flag_w = 2'b11; no_write = 1'b1; end
`endif
      default: begin dp_ctrl = 2'b00; flag_w = 2'b00; end
    endcase
    // S bit clear: the instruction never touches the flags
    if (!Funct[0]) flag_w = 2'b00;
  end

  // ---------------- condition check against the flag register ----------------
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (Cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;   // 1111: executes as a no-op
    endcase
  end

  // ---------------- state, flags and condition registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      flags     <= 4'b0000;
      cond_ex_r <= 1'b0;
    end else begin
      state <= state_next;
      if (state == DECODE) cond_ex_r <= cond_ex;
      if (((state == EXECUTER) || (state == EXECUTEI)) && cond_ex_r) begin
        if (flag_w[1]) flags[3:2] <= ALUFlags[3:2];
        if (flag_w[0]) flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  // ---------------- next state ----------------
  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:    state_next = DECODE;
      DECODE: begin
        case (Op)
          2'b01:   state_next = MEMADR;
          2'b00:   state_next = Funct[5] ? EXECUTEI : EXECUTER;
          2'b10:   state_next = BRANCH;
          default: state_next = FETCH;
        endcase
      end
      MEMADR:   state_next = Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  state_next = MEMWB;
      EXECUTER: state_next = ALUWB;
      EXECUTEI: state_next = ALUWB;
      default:  state_next = FETCH;
    endcase
  end

  // ---------------- Moore outputs ----------------
  // Compare-style instructions suppress writeback in ALUWB only.
  assign wb_en = cond_ex_r & ~((state == ALUWB) & no_write);

  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 2'b00;
    RegWrite   = 1'b0;
    case (state)
      FETCH: begin
        IRWrite = 1'b1; PCWrite = 1'b1;
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      MEMADR:   ALUSrcB = 2'b01;
      MEMREAD:  AdrSrc = 1'b1;
      MEMWRITE: begin AdrSrc = 1'b1; MemWrite = cond_ex_r; end
      EXECUTER: ALUControl = dp_ctrl;
      EXECUTEI: begin ALUSrcB = 2'b01; ALUControl = dp_ctrl; end
      BRANCH: begin
        ALUSrcB = 2'b01; ResultSrc = 2'b10; PCWrite = cond_ex_r;
      end
      MEMWB, ALUWB: begin
        if (state == MEMWB) ResultSrc = 2'b01;
        if (Rd == 4'hF) PCWrite  = wb_en;
        else            RegWrite = wb_en;
      end
      default: ;
    endcase
    // Architectural enables are held off for as long as reset is low
    if (!reset) begin
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
    end
  end

  assign ImmSrc = Op;
  assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_controller
// Description : Directed bench for mc_controller. Each instruction pushes the
//               expected per-cycle control vector to a queue; one entry is
//               popped and compared every cycle. Flag state is observed
//               indirectly through later conditional branches.
// Optional    : CMP_NOWB_EN selects the compare-instruction expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0] ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  mc_controller dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .RegWrite(RegWrite)
  );

  always #5 clk = ~clk;

  // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,RegWrite}
  function automatic logic [11:0] vec(input bit pcw, input bit adr,
      input bit mw, input bit irw, input logic [1:0] rs, input bit sa,
      input logic [1:0] sb, input logic [1:0] ac, input bit rw);
    return {pcw, adr, mw, irw, rs, sa, sb, ac, rw};
  endfunction

  function automatic logic [11:0] obs();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
            ALUSrcB, ALUControl, RegWrite};
  endfunction

  function automatic logic [11:0] V_F();  return vec(1,0,0,1,2'b10,1,2'b10,2'b00,0); endfunction
  function automatic logic [11:0] V_D();  return vec(0,0,0,0,2'b10,1,2'b10,2'b00,0); endfunction
  function automatic logic [11:0] V_RST(); return vec(0,0,0,0,2'b10,1,2'b10,2'b00,0); endfunction
  function automatic logic [11:0] V_MA(); return vec(0,0,0,0,2'b00,0,2'b01,2'b00,0); endfunction
  function automatic logic [11:0] V_MR(); return vec(0,1,0,0,2'b00,0,2'b00,2'b00,0); endfunction
  function automatic logic [11:0] V_MWB(input bit pc, input bit rw); return vec(pc,0,0,0,2'b01,0,2'b00,2'b00,rw); endfunction
  function automatic logic [11:0] V_MW(input bit mw); return vec(0,1,mw,0,2'b00,0,2'b00,2'b00,0); endfunction
  function automatic logic [11:0] V_ER(input logic [1:0] ac); return vec(0,0,0,0,2'b00,0,2'b00,ac,0); endfunction
  function automatic logic [11:0] V_EI(input logic [1:0] ac); return vec(0,0,0,0,2'b00,0,2'b01,ac,0); endfunction
  function automatic logic [11:0] V_AWB(input bit pc, input bit rw); return vec(pc,0,0,0,2'b00,0,2'b00,2'b00,rw); endfunction
  function automatic logic [11:0] V_BR(input bit pc); return vec(pc,0,0,0,2'b10,0,2'b01,2'b00,0); endfunction

  task automatic check_vec(input string tag, input logic [11:0] expv);
    checks++;
    assert (obs() === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs(), expv);
    end
  endtask

  task automatic check2(input string tag, input logic [1:0] o, input logic [1:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  // Compare one scoreboard entry, then advance to 1 time unit past the edge.
  task automatic step(input string tag);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty", tag);
    end else begin
      check_vec(tag, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input logic [3:0] c, input logic [1:0] o,
      input logic [5:0] f, input logic [3:0] r, input logic [3:0] fl);
    Cond = c; Op = o; Funct = f; Rd = r; ALUFlags = fl;
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) step(tag);
  endtask

  task automatic branch(input string tag, input logic [3:0] c, input bit taken);
    exp_q.push_back(V_F()); exp_q.push_back(V_D()); exp_q.push_back(V_BR(taken));
    run(tag, c, 2'b10, 6'b000000, 4'd0, 4'b0000);
  endtask

  initial begin
    reset = 1'b0; Cond = 4'hE; Op = 2'b10; Funct = '0; Rd = '0; ALUFlags = '0;
    #12;
    check_vec("reset_outputs", V_RST());
    check2("regsrc_b", RegSrc, 2'b01);
    check2("immsrc_b", ImmSrc, 2'b10);
    Op = 2'b01; #0.5;
    check2("regsrc_mem", RegSrc, 2'b10);
    check2("immsrc_mem", ImmSrc, 2'b01);
    reset = 1'b1;
    #0.5;

    // Flags reset to 0: BEQ not taken
    branch("beq_reset_flags", 4'b0000, 1'b0);

    // ADDS immediate, Rd=3, ALU reports Z
    exp_q.push_back(V_F()); exp_q.push_back(V_D());
    exp_q.push_back(V_EI(2'b00)); exp_q.push_back(V_AWB(0, 1));
    run("adds_imm", 4'hE, 2'b00, 6'b101001, 4'd3, 4'b0100);
    branch("beq_after_adds", 4'b0000, 1'b1);

    // ANDS with NE while Z=1: suppressed, flags unchanged
    exp_q.push_back(V_F()); exp_q.push_back(V_D());
    exp_q.push_back(V_ER(2'b10)); exp_q.push_back(V_AWB(0, 0));
    run("ands_ne_skip", 4'b0001, 2'b00, 6'b000001, 4'd2, 4'b1000);
    branch("beq_after_ands_skip", 4'b0000, 1'b1);
    branch("bmi_after_ands_skip", 4'b0100, 1'b0);

    // LDR to PC
    exp_q.push_back(V_F()); exp_q.push_back(V_D()); exp_q.push_back(V_MA());
    exp_q.push_back(V_MR()); exp_q.push_back(V_MWB(1, 0));
    run("ldr_pc", 4'hE, 2'b01, 6'b011001, 4'd15, 4'b0000);

    // STR with Cond=1111: never writes
    exp_q.push_back(V_F()); exp_q.push_back(V_D()); exp_q.push_back(V_MA());
    exp_q.push_back(V_MW(0));
    run("str_nv", 4'hF, 2'b01, 6'b011000, 4'd2, 4'b0000);

    // Undefined Op: two cycles
    exp_q.push_back(V_F()); exp_q.push_back(V_D());
    run("undef_op", 4'hE, 2'b11, 6'b000000, 4'd1, 4'b1111);

    // SUBS register: flags -> 0011
    exp_q.push_back(V_F()); exp_q.push_back(V_D());
    exp_q.push_back(V_ER(2'b01)); exp_q.push_back(V_AWB(0, 1));
    run("subs_reg", 4'hE, 2'b00, 6'b000101, 4'd4, 4'b0011);
    branch("beq_after_subs", 4'b0000, 1'b0);
    branch("bvs_after_subs", 4'b0110, 1'b1);

    // ORR without S: flags untouched
    exp_q.push_back(V_F()); exp_q.push_back(V_D());
    exp_q.push_back(V_ER(2'b11)); exp_q.push_back(V_AWB(0, 1));
    run("orr_nos", 4'hE, 2'b00, 6'b011000, 4'd6, 4'b1100);
    branch("beq_after_orr", 4'b0000, 1'b0);

    // ANDS: loads N,Z only; C,V survive
    exp_q.push_back(V_F()); exp_q.push_back(V_D());
    exp_q.push_back(V_ER(2'b10)); exp_q.push_back(V_AWB(0, 1));
    run("ands_al", 4'hE, 2'b00, 6'b000001, 4'd7, 4'b1000);
    branch("bmi_after_ands", 4'b0100, 1'b1);
    branch("bvs_after_ands", 4'b0110, 1'b1);

    // ADD to PC: writeback goes to PC
    exp_q.push_back(V_F()); exp_q.push_back(V_D());
    exp_q.push_back(V_ER(2'b00)); exp_q.push_back(V_AWB(1, 0));
    run("add_pc", 4'hE, 2'b00, 6'b001000, 4'd15, 4'b0000);

    // Funct[4:1]=1010 with S=1
    exp_q.push_back(V_F()); exp_q.push_back(V_D());
`ifdef CMP_NOWB_EN
    exp_q.push_back(V_ER(2'b01)); exp_q.push_back(V_AWB(0, 0));
    run("cmp", 4'hE, 2'b00, 6'b010101, 4'd5, 4'b0110);
    branch("beq_after_cmp", 4'b0000, 1'b1);
    branch("bmi_after_cmp", 4'b0100, 1'b0);
`else
    exp_q.push_back(V_ER(2'b00)); exp_q.push_back(V_AWB(0, 1));
    run("cmp_as_add", 4'hE, 2'b00, 6'b010101, 4'd5, 4'b0110);
    branch("beq_after_1010", 4'b0000, 1'b0);
    branch("bmi_after_1010", 4'b0100, 1'b1);
`endif
    branch("bcs_before_reset", 4'b0010, 1'b1);

    // STR AL, reset asserted in the middle of MEMWRITE
    exp_q.push_back(V_F()); exp_q.push_back(V_D()); exp_q.push_back(V_MA());
    run("str_al", 4'hE, 2'b01, 6'b011000, 4'd2, 4'b0000);
    check_vec("str_memwrite", V_MW(1));
    #2;
    reset = 1'b0;
    #0.5;
    checks++;
    assert (MemWrite === 1'b0) else begin
      errors++;
      $error("FAIL memwrite_async_drop: observed %b expected 0", MemWrite);
    end
    check_vec("reset_mid_memwrite", V_RST());
    @(posedge clk); #1;
    check_vec("reset_held", V_RST());
    #2;
    reset = 1'b1;
    #0.5;
    check_vec("first_fetch_after_reset", V_F());
    @(posedge clk); #1;
    exp_q.push_back(V_D()); exp_q.push_back(V_BR(0));
    run("bcs_after_reset", 4'b0010, 2'b10, 6'b000000, 4'd0, 4'b0000);
    exp_q.push_back(V_F());
    run("final_fetch", 4'hE, 2'b11, 6'b000000, 4'd0, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
